// File: rtl/bcd_2421_to_8421_framer.sv
// Collects NDIG 2421 (Aiken) digits into one frame and presents it as packed
// 8421 BCD plus its binary value, with a sticky invalid-code flag.
module bcd_2421_to_8421_framer #(
    parameter int NDIG = 4,
    parameter int BINW = 14
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           in_digit,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NDIG-1:0]    out_bcd,
    output logic [BINW-1:0]      out_bin,
    output logic                 out_err
);

    localparam int CW = $clog2(NDIG + 1);
    localparam int BW = 4 * NDIG;

    typedef enum logic {S_COLLECT, S_HOLD} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [BW-1:0]   r_bcd;
    logic [BINW-1:0] r_bin;
    logic            r_err;

    logic [3:0]      w_dec;
    logic            w_bad;
    logic            w_accept;
    logic            w_last;
    logic [BW-1:0]   w_bcd_next;
    logic [BINW-1:0] w_bin_next;

    // Codes 0101..1010 are outside the Aiken set; they decode as 0 and flag.
    always_comb begin
        w_dec = 4'd0;
        w_bad = 1'b0;
        case (in_digit)
            4'b0000: w_dec = 4'd0;
            4'b0001: w_dec = 4'd1;
            4'b0010: w_dec = 4'd2;
            4'b0011: w_dec = 4'd3;
            4'b0100: w_dec = 4'd4;
            4'b1011: w_dec = 4'd5;
            4'b1100: w_dec = 4'd6;
            4'b1101: w_dec = 4'd7;
            4'b1110: w_dec = 4'd8;
            4'b1111: w_dec = 4'd9;
            default: w_bad = 1'b1;
        endcase
    end

    assign w_accept   = in_valid && (r_state == S_COLLECT);
    assign w_last     = (r_cnt == CW'(NDIG - 1));
    assign w_bcd_next = (r_bcd << 4) | BW'(w_dec);
    assign w_bin_next = r_bin * BINW'(10) + BINW'(w_dec);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_COLLECT;
            r_cnt   <= '0;
            r_bcd   <= '0;
            r_bin   <= '0;
            r_err   <= 1'b0;
        end else if (clr) begin
            r_state <= S_COLLECT;
            r_cnt   <= '0;
            r_bcd   <= '0;
            r_bin   <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_COLLECT: begin
                    if (w_accept) begin
                        r_bcd <= w_bcd_next;
                        r_bin <= w_bin_next;
                        r_err <= r_err | w_bad;
                        r_cnt <= r_cnt + CW'(1);
                        if (w_last) r_state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    // Handshake cycle accepts nothing: one bubble per frame.
                    if (out_ready) begin
                        r_state <= S_COLLECT;
                        r_cnt   <= '0;
                        r_bcd   <= '0;
                        r_bin   <= '0;
                        r_err   <= 1'b0;
                    end
                end
                default: r_state <= S_COLLECT;
            endcase
        end
    end

    assign in_ready  = (r_state == S_COLLECT);
    assign out_valid = (r_state == S_HOLD);
    assign out_bcd   = r_bcd;
    assign out_bin   = r_bin;
    assign out_err   = r_err;

endmodule

// File: tb/tb_bcd_2421_to_8421_framer.sv
// Randomized and directed checks of the 2421->8421 framer against an
// arithmetic reference model (Aiken weights 2-4-2-1).
module tb_bcd_2421_to_8421_framer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_digit = 4'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_bcd;
    logic [13:0] out_bin;
    logic        out_err;

    int n_tests = 0;
    int n_fail  = 0;

    bcd_2421_to_8421_framer #(.NDIG(4), .BINW(14)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_digit(in_digit),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_bcd(out_bcd), .out_bin(out_bin), .out_err(out_err)
    );

    always #5 clk = ~clk;

    // Reference: digit value from the 2-4-2-1 weights; 0101..1010 are illegal.
    function automatic void model(input logic [15:0] codes, output logic [15:0] bcd,
                                  output int bin, output logic err);
        logic [3:0] c;
        int v;
        bcd = 16'd0; bin = 0; err = 1'b0;
        for (int i = 0; i < 4; i++) begin
            c = codes[15-4*i -: 4];
            v = 2*int'(c[3]) + 4*int'(c[2]) + 2*int'(c[1]) + int'(c[0]);
            if (c >= 4'd5 && c <= 4'd10) begin
                err = 1'b1;
                v = 0;
            end
            bcd = bcd * 16 + 16'(v);
            bin = bin * 10 + v;
        end
    endfunction

    task automatic feed(input logic [3:0] d, input int gap);
        for (int g = 0; g < gap; g++) begin
            @(negedge clk); in_valid = 1'b0; in_digit = 4'($urandom);
        end
        @(negedge clk); in_valid = 1'b1; in_digit = d;
        @(posedge clk);
    endtask

    task automatic feed_frame(input logic [15:0] codes, input int maxgap);
        for (int i = 0; i < 4; i++) feed(codes[15-4*i -: 4], $urandom_range(maxgap, 0));
        @(negedge clk); in_valid = 1'b0;
    endtask

    task automatic consume();
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk); out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_bcd !== 16'd0 ||
            out_bin !== 14'd0 || out_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: v=%b r=%b bcd=%h bin=%0d err=%b, need v=0 r=1 bcd=0 bin=0 err=0",
                     out_valid, in_ready, out_bcd, out_bin, out_err);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [15:0] codes [4] = '{16'h1234, 16'hFFFF, 16'hB5E0, 16'h1234};
        logic [15:0] ebcd  [4] = '{16'h1234, 16'h9999, 16'h5080, 16'h1234};
        int          ebin  [4] = '{1234, 9999, 5080, 1234};
        logic        eerr  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 4; k++) begin
            feed_frame(codes[k], 0);
            n_tests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_bcd !== ebcd[k] ||
                out_bin !== 14'(ebin[k]) || out_err !== eerr[k]) begin
                n_fail++;
                $display("FAIL directed[%0d]: v=%b r=%b bcd=%h bin=%0d err=%b, need v=1 r=0 bcd=%h bin=%0d err=%b",
                         k, out_valid, in_ready, out_bcd, out_bin, out_err, ebcd[k], ebin[k], eerr[k]);
            end
            consume();
            n_tests++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_bcd !== 16'd0 || out_err !== 1'b0) begin
                n_fail++;
                $display("FAIL directed_release[%0d]: v=%b r=%b bcd=%h err=%b, need v=0 r=1 bcd=0 err=0",
                         k, out_valid, in_ready, out_bcd, out_err);
            end
        end
    endtask

    task automatic test_backpressure();
        feed_frame(16'h1234, 0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_tests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_bcd !== 16'h1234 ||
                out_bin !== 14'd1234 || out_err !== 1'b0) begin
                n_fail++;
                $display("FAIL backpressure[%0d]: v=%b r=%b bcd=%h bin=%0d err=%b, need v=1 r=0 bcd=1234 bin=1234 err=0",
                         c, out_valid, in_ready, out_bcd, out_bin, out_err);
            end
            in_valid = 1'b1; in_digit = 4'($urandom); out_ready = 1'b0;
        end
        @(negedge clk); out_ready = 1'b1; in_valid = 1'b1; in_digit = 4'b1111;
        @(posedge clk);
        @(negedge clk); out_ready = 1'b0; in_valid = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_bcd !== 16'd0 || out_bin !== 14'd0) begin
            n_fail++;
            $display("FAIL bubble: v=%b r=%b bcd=%h bin=%0d, need v=0 r=1 bcd=0 bin=0",
                     out_valid, in_ready, out_bcd, out_bin);
        end
        feed_frame(16'hFEDC, 1);
        n_tests++;
        if (out_valid !== 1'b1 || out_bcd !== 16'h9876 || out_bin !== 14'd9876 || out_err !== 1'b0) begin
            n_fail++;
            $display("FAIL after_backpressure: v=%b bcd=%h bin=%0d err=%b, need v=1 bcd=9876 bin=9876 err=0",
                     out_valid, out_bcd, out_bin, out_err);
        end
        consume();
    endtask

    task automatic test_clr();
        feed(4'b0001, 0);
        feed(4'b0010, 0);
        @(negedge clk); in_valid = 1'b0; clr = 1'b1;
        @(posedge clk);
        @(negedge clk); clr = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_bcd !== 16'd0 || out_bin !== 14'd0) begin
            n_fail++;
            $display("FAIL clr_partial: v=%b r=%b bcd=%h bin=%0d, need v=0 r=1 bcd=0 bin=0",
                     out_valid, in_ready, out_bcd, out_bin);
        end
        feed_frame(16'h34BC, 0);
        n_tests++;
        if (out_valid !== 1'b1 || out_bcd !== 16'h3456 || out_bin !== 14'd3456 || out_err !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_frame: v=%b bcd=%h bin=%0d err=%b, need v=1 bcd=3456 bin=3456 err=0",
                     out_valid, out_bcd, out_bin, out_err);
        end
        consume();
        feed(4'b0001, 0);
        feed(4'b0010, 0);
        feed(4'b0101, 0);
        @(negedge clk); in_valid = 1'b1; in_digit = 4'b0100; clr = 1'b1;
        @(posedge clk);
        @(negedge clk); clr = 1'b0; in_valid = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_bcd !== 16'd0 || out_err !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_4th: v=%b r=%b bcd=%h err=%b, need v=0 r=1 bcd=0 err=0",
                     out_valid, in_ready, out_bcd, out_err);
        end
        feed_frame(16'hFFFF, 0);
        n_tests++;
        if (out_valid !== 1'b1 || out_bcd !== 16'h9999 || out_bin !== 14'd9999 || out_err !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_4th_next: v=%b bcd=%h bin=%0d err=%b, need v=1 bcd=9999 bin=9999 err=0",
                     out_valid, out_bcd, out_bin, out_err);
        end
        consume();
    endtask

    task automatic test_reset_mid();
        feed(4'b0001, 0);
        feed(4'b0010, 0);
        @(negedge clk); in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_bcd !== 16'd0 || out_bin !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_mid: v=%b r=%b bcd=%h bin=%0d, need v=0 r=1 bcd=0 bin=0",
                     out_valid, in_ready, out_bcd, out_bin);
        end
        @(negedge clk); rst_n = 1'b1; in_valid = 1'b1; in_digit = 4'b0001;
        @(posedge clk);
        feed(4'b0010, 0);
        feed(4'b0011, 0);
        feed(4'b0100, 0);
        @(negedge clk); in_valid = 1'b0;
        n_tests++;
        if (out_valid !== 1'b1 || out_bcd !== 16'h1234 || out_bin !== 14'd1234) begin
            n_fail++;
            $display("FAIL reset_first_edge: v=%b bcd=%h bin=%0d, need v=1 bcd=1234 bin=1234",
                     out_valid, out_bcd, out_bin);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_bin !== 14'd0 || out_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: v=%b r=%b bin=%0d err=%b, need v=0 r=1 bin=0 err=0",
                     out_valid, in_ready, out_bin, out_err);
        end
        @(negedge clk); rst_n = 1'b1;
        feed_frame(16'hB5E0, 0);
        n_tests++;
        if (out_valid !== 1'b1 || out_bcd !== 16'h5080 || out_bin !== 14'd5080 || out_err !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_fresh: v=%b bcd=%h bin=%0d err=%b, need v=1 bcd=5080 bin=5080 err=1",
                     out_valid, out_bcd, out_bin, out_err);
        end
        consume();
    endtask

    task automatic test_random();
        logic [15:0] codes, ebcd;
        int          ebin;
        logic        eerr;
        for (int f = 0; f < 30; f++) begin
            codes = 16'($urandom);
            model(codes, ebcd, ebin, eerr);
            feed_frame(codes, 2);
            n_tests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_bcd !== ebcd ||
                out_bin !== 14'(ebin) || out_err !== eerr) begin
                n_fail++;
                $display("FAIL random[%0d] codes=%h: v=%b r=%b bcd=%h bin=%0d err=%b, need v=1 r=0 bcd=%h bin=%0d err=%b",
                         f, codes, out_valid, in_ready, out_bcd, out_bin, out_err, ebcd, ebin, eerr);
            end
            for (int h = 0, n = $urandom_range(3, 0); h < n; h++) begin
                @(negedge clk); in_valid = 1'($urandom); in_digit = 4'($urandom);
                @(negedge clk);
                n_tests++;
                if (out_valid !== 1'b1 || out_bcd !== ebcd || out_bin !== 14'(ebin) || out_err !== eerr) begin
                    n_fail++;
                    $display("FAIL random_hold[%0d]: v=%b bcd=%h bin=%0d err=%b, need v=1 bcd=%h bin=%0d err=%b",
                             f, out_valid, out_bcd, out_bin, out_err, ebcd, ebin, eerr);
                end
            end
            in_valid = 1'b0;
            consume();
            n_tests++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_bin !== 14'd0 || out_err !== 1'b0) begin
                n_fail++;
                $display("FAIL random_release[%0d]: v=%b r=%b bin=%0d err=%b, need v=0 r=1 bin=0 err=0",
                         f, out_valid, in_ready, out_bin, out_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_clr();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_2421_to_8421_framer.md
BCD_2421_TO_8421_FRAMER -- requirements
Module: bcd_2421_to_8421_framer

Interface
REQ-001 Parameter NDIG, default 4: decimal digits per frame (range 1..4).
REQ-002 Parameter BINW, default 14: binary output width; must hold 10^NDIG-1.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Port clr, input, 1: synchronous frame abort.
REQ-006 Port in_valid, input, 1: in_digit is presented.
REQ-007 Port in_ready, output, 1: block accepts a digit this cycle.
REQ-008 Port in_digit, input, 4: one 2421 (Aiken) coded digit.
REQ-009 Port out_valid, output, 1: completed frame is presented.
REQ-010 Port out_ready, input, 1: consumer takes the frame.
REQ-011 Port out_bcd, output, 4*NDIG: frame as packed 8421 BCD; the first digit received occupies the most significant nibble.
REQ-012 Port out_bin, output, BINW: binary value of the frame.
REQ-013 Port out_err, output, 1: the frame contained at least one invalid 2421 code.

Function
REQ-014 A digit SHALL be accepted only on a cycle with in_valid=1 and in_ready=1; in_digit is ignored on all other cycles.
REQ-015 The decode SHALL be 0000->0, 0001->1, 0010->2, 0011->3, 0100->4, 1011->5, 1100->6, 1101->7, 1110->8, 1111->9.
REQ-016 Codes 0101..1010 SHALL be invalid: decoded digit 0 is substituted, and the frame error flag is set sticky until the frame ends.
REQ-017 The FSM SHALL have two states. COLLECT: in_ready=1, out_valid=0. HOLD: in_ready=0, out_valid=1.
REQ-018 In COLLECT, each accepted digit d SHALL update three items in the same edge: bcd_acc = (bcd_acc<<4)|d; bin_acc = bin_acc*10+d, truncated to BINW; digit count +1.
REQ-019 Acceptance of digit number NDIG SHALL move the FSM to HOLD.
REQ-019a out_valid SHALL rise on the first cycle after that acceptance, with out_bcd, out_bin and out_err final.
REQ-020 In HOLD, out_bcd, out_bin and out_err SHALL stay stable while out_ready=0, for any number of cycles.
REQ-021 In HOLD with out_ready=1, the FSM SHALL return to COLLECT next cycle and clear the count, accumulators and error flag.
REQ-021a No digit SHALL be accepted in that handshake cycle, so there is a one-cycle bubble per frame.
REQ-022 The digit count SHALL wrap to 0 only through REQ-021 or clr; it never exceeds NDIG.
REQ-023 clr=1 SHALL force COLLECT next cycle, with count, accumulators, error and out_valid cleared.
REQ-023a clr SHALL override a simultaneous digit acceptance or output handshake; the digit is dropped.
REQ-024 out_bcd, out_bin and out_err SHALL be registered; in_ready and out_valid decode directly from the state register.
REQ-025 Outside HOLD, out_bcd, out_bin and out_err SHALL show the partial accumulators.

Reset
REQ-026 While rst_n=0, the block SHALL hold state COLLECT, count=0, out_valid=0, in_ready=1, out_bcd=0, out_bin=0, out_err=0.
REQ-027 Assertion of rst_n SHALL take effect immediately without a clock edge, including mid-frame and in HOLD; the partial frame is discarded.
REQ-028 After rst_n deasserts, the first rising edge SHALL be able to accept a digit.

Verification
REQ-029 Digits 0001, 0010, 0011, 0100 back-to-back -> one cycle after the 4th accept: out_valid=1, out_bcd=0x1234, out_bin=1234, out_err=0.
REQ-030 Digits 1111 x4 -> out_bcd=0x9999, out_bin=9999, out_err=0.
REQ-031 Digits 1011, 0101, 1110, 0000 -> out_bcd=0x5080, out_bin=5080, out_err=1; the next clean frame reports out_err=0.
REQ-032 Backpressure case: out_ready=0 for 5 cycles in HOLD with in_valid=1 -> outputs unchanged, in_ready=0, no digit consumed.
REQ-032a Continuation: out_ready=1 -> COLLECT next cycle, then the next frame decodes correctly.
REQ-033 clr case: clr after 2 digits (0001, 0010), then 0011, 0100, 1011, 1100 -> out_bcd=0x3456, out_bin=3456.
REQ-033a clr in the same cycle as the 4th accept -> no frame emitted.
REQ-034 Reset case: rst_n pulsed low mid-frame or in HOLD -> out_valid=0 before the next edge; subsequent 4 digits form a fresh frame.
